// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Buffered UART transmitter: circular byte FIFO feeding a
//            start/data(LSB first)/optional even parity/stop serialiser.
// Revision : 1.0  initial release
// ============================================================================

module uart_tx #(
  parameter int BaudRate     = 9600,
  parameter int ParityBit    = 0,
  parameter int DataBitsSize = 8,
  parameter int StopBits     = 1,
  parameter int BufferSize   = 64,
  parameter int ClockFreqHz  = 10000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(BufferSize):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx_sig
);

  localparam int PW   = $clog2(BufferSize);
  localparam int SCLK = ClockFreqHz / BaudRate;
  localparam int CW   = $clog2(StopBits * SCLK + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(SCLK - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(StopBits * SCLK - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DataBitsSize - 1);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DataBitsSize) - 1);
  localparam logic [PW:0]   DEPTH     = (PW + 1)'(BufferSize);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    data_cnt_q, data_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          full_q, empty_q, overflow_q;
  logic [7:0]    mem_q [BufferSize];

  logic       push, pop;
  logic       bit_done, stop_done, last_bit;
  logic [7:0] head;

  assign bit_done  = (bit_cnt_q == BIT_LAST);
  assign stop_done = (bit_cnt_q == STOP_LAST);
  assign last_bit  = (data_cnt_q == DATA_LAST);
  assign head      = mem_q[rd_ptr_q];

  // Full/empty are the registered flags, so a push into a full FIFO is dropped
  // even when a pop frees a slot in the same cycle.
  assign push = wr_en && !full_q;
  assign pop  = !empty_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_done));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty_q) state_d = S_START;
      S_START:  if (bit_done) state_d = S_DATA;
      S_DATA:   if (bit_done && last_bit) state_d = (ParityBit != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (stop_done) state_d = empty_q ? S_IDLE : S_START;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q + CW'(1);
    data_cnt_d = data_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          bit_cnt_d  = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          data_cnt_d = data_cnt_q + 3'd1;
          if (last_bit) begin
            tx_d = (ParityBit != 0) ? par_q : 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (stop_done) begin
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      default: begin
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase
    // Loading the next byte overrides the per-state update, giving gapless frames.
    if (pop) begin
      shift_d    = head;
      par_d      = ^(head & DATA_MASK);
      bit_cnt_d  = '0;
      data_cnt_d = '0;
      tx_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      data_cnt_q <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      data_cnt_q <= data_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != S_IDLE);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH);
      empty_q    <= (count_d == '0);
      overflow_q <= wr_en && full_q;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx_sig   = tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx: two parameterisations, a
//            queue scoreboard and a serial-frame monitor per instance.
// Revision : 1.0  initial release
// ============================================================================

module tb_uart_tx;

  localparam int SCLK = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wr_en_a, wr_en_b;
  logic [7:0] wr_data_a, wr_data_b;
  logic       full_a, empty_a, ovf_a, busy_a, tx_a;
  logic       full_b, empty_b, ovf_b, busy_b, tx_b;
  logic [6:0] level_a;
  logic [2:0] level_b;

  uart_tx #(.BaudRate(100), .ParityBit(0), .DataBitsSize(8), .StopBits(1),
            .BufferSize(64), .ClockFreqHz(1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .empty(empty_a), .level(level_a), .overflow(ovf_a),
    .busy(busy_a), .tx_sig(tx_a)
  );

  uart_tx #(.BaudRate(100), .ParityBit(1), .DataBitsSize(7), .StopBits(2),
            .BufferSize(4), .ClockFreqHz(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .empty(empty_b), .level(level_b), .overflow(ovf_b),
    .busy(busy_b), .tx_sig(tx_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  bit in_frame[2];
  int last_start[2];
  int prev_start[2];
  int frames[2];

  function automatic logic get_tx(input int d);
    return (d == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic logic [7:0] qpop(input int d);
    if (d == 0) return q_a.pop_front();
    return q_b.pop_front();
  endfunction

  function automatic int nslots(input int d);
    return (d == 0) ? 10 : 11;
  endfunction

  // Expected line level in bit slot s of a frame carrying byte b.
  function automatic logic exp_bit(input int d, input logic [7:0] b, input int s);
    int db;
    logic [7:0] m;
    db = (d == 0) ? 8 : 7;
    m  = 8'((1 << db) - 1);
    if (s == 0) return 1'b0;
    if (s <= db) return b[s-1];
    if (d == 1 && s == db + 1) return (($countones(b & m) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor(input int d);
    logic [7:0] b;
    logic       e, bad_v, bad_b, bad_e;
    bit         abort, bad, known;
    int         bad_c;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || get_tx(d) !== 1'b0) continue;
      in_frame[d]   = 1'b1;
      prev_start[d] = last_start[d];
      last_start[d] = cyc;
      frames[d]++;
      known = (qsize(d) != 0);
      b     = known ? qpop(d) : 8'h00;
      if (!known) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame dut%0d: start bit at cycle %0d with nothing queued", d, cyc);
      end
      bad = 1'b0;
      abort = 1'b0;
      bad_c = 0; bad_v = 1'b0; bad_b = 1'b0; bad_e = 1'b0;
      for (int c = 0; c < nslots(d) * SCLK; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          abort = 1'b1;
          break;
        end
        e = exp_bit(d, b, c / SCLK);
        if (!bad && (get_tx(d) !== e || get_busy(d) !== 1'b1)) begin
          bad = 1'b1; bad_c = c; bad_v = get_tx(d); bad_b = get_busy(d); bad_e = e;
        end
      end
      in_frame[d] = 1'b0;
      if (!abort && known) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL frame dut%0d byte %02h at frame cycle %0d: tx=%b busy=%b, expected tx=%b busy=1",
                   d, b, bad_c, bad_v, bad_b, bad_e);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b || in_frame[0] || in_frame[1])
           && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s: not drained after %0d cycles (queued a=%0d b=%0d)", name, n, q_a.size(), q_b.size());
    end
  endtask

  task automatic push1(input int d, input logic [7:0] b);
    if (d == 0) begin
      wr_en_a = 1'b1; wr_data_a = b; q_a.push_back(b);
    end else begin
      wr_en_b = 1'b1; wr_data_b = b; q_b.push_back(b);
    end
    @(negedge clk);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0;
    logic [7:0] b;
    bit quiet_bad;

    rst_n = 1'b0;
    wr_en_a = 1'b0; wr_en_b = 1'b0;
    wr_data_a = 8'h00; wr_data_b = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_tx_a", tx_a, 1);     chk("rst_busy_a", busy_a, 0);
    chk("rst_full_a", full_a, 0); chk("rst_empty_a", empty_a, 1);
    chk("rst_level_a", level_a, 0); chk("rst_ovf_a", ovf_a, 0);
    chk("rst_tx_b", tx_b, 1);     chk("rst_empty_b", empty_b, 1);
    chk("rst_level_b", level_b, 0); chk("rst_busy_b", busy_b, 0);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start-bit latency, empty timing and busy window.
    c0 = cyc;
    push1(0, 8'h55);
    chk("t1_empty_c1", empty_a, 0);
    @(negedge clk);
    chk("t1_empty_c2", empty_a, 1);
    chk("t1_tx_c2", tx_a, 0);
    chk("t1_busy_c2", busy_a, 1);
    while (cyc < c0 + 101) @(negedge clk);
    chk("t1_busy_c101", busy_a, 1);
    @(negedge clk);
    chk("t1_busy_c102", busy_a, 0);
    chk("t1_tx_c102", tx_a, 1);
    chk("t1_start_cycle", last_start[0], c0 + 2);
    wait_drain("t1_drain", 500);

    // Parity, 7-bit data, 2 stop bits, back-to-back frames on dut_b.
    push1(1, 8'h07);
    push1(1, 8'h03);
    push1(1, 8'hFF);
    wait_drain("t2_drain", 1000);
    chk("t2_frame_spacing_b", last_start[1] - prev_start[1], 110);
    chk("t2_frames_b", frames[1], 3);

    // Back-to-back frames on dut_a.
    push1(0, 8'hA5);
    push1(0, 8'h3C);
    wait_drain("t3_drain", 1000);
    chk("t3_frame_spacing_a", last_start[0] - prev_start[0], 100);

    // Fill to full and overflow.
    c0 = cyc;
    for (int i = 0; i < 66; i++) begin
      b = 8'($urandom);
      wr_en_a = 1'b1;
      wr_data_a = b;
      if (i < 65) q_a.push_back(b);
      if (i == 65) begin
        chk("t4_level_full", level_a, 64);
        chk("t4_full", full_a, 1);
        chk("t4_ovf_before", ovf_a, 0);
      end
      @(negedge clk);
    end
    wr_en_a = 1'b0;
    chk("t4_ovf_pulse", ovf_a, 1);
    @(negedge clk);
    chk("t4_ovf_cleared", ovf_a, 0);
    chk("t4_level_after", level_a, 64);
    wait_drain("t4_drain", 8000);
    chk("t4_cycles_used", (cyc - c0 > 6500) ? 1 : 0, 1);

    // Random traffic on both instances, never exceeding FIFO capacity.
    for (int t = 0; t < 2500; t++) begin
      if ($urandom_range(0, 7) == 0 && q_a.size() < 63) begin
        b = 8'($urandom);
        wr_en_a = 1'b1; wr_data_a = b; q_a.push_back(b);
      end
      if ($urandom_range(0, 15) == 0 && q_b.size() < 3) begin
        b = 8'($urandom);
        wr_en_b = 1'b1; wr_data_b = b; q_b.push_back(b);
      end
      @(negedge clk);
      wr_en_a = 1'b0;
      wr_en_b = 1'b0;
    end
    wait_drain("random_drain", 20000);

    // Asynchronous reset mid-DATA with bytes still queued.
    c0 = cyc;
    push1(0, 8'h00);
    for (int i = 0; i < 4; i++) push1(0, 8'($urandom));
    while (cyc < c0 + 20) @(negedge clk);
    chk("t6_pre_tx", tx_a, 0);
    chk("t6_pre_level", level_a, 4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_tx", tx_a, 1);
    chk("t6_rst_level", level_a, 0);
    chk("t6_rst_empty", empty_a, 1);
    chk("t6_rst_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    q_a.delete();
    q_b.delete();
    rst_n = 1'b1;
    f0 = frames[0];
    quiet_bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) quiet_bad = 1'b1;
    end
    chk("t6_quiet_after_reset", quiet_bad, 0);
    chk("t6_no_new_frames", frames[0] - f0, 0);
    chk("t6_level_after", level_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
